idu_pipe: RTL and testbench
===========================

// Module: idu_pipe
// PURPOSE
//   Registered decode stage for the NPC core. Sits between the IFU and the EXU.
//   Decodes RV32E/RV32I instruction fields and the immediate into a one-entry
//   output pipeline register with a valid/ready handshake on both sides.
//   A per-register pending-write scoreboard stalls RAW hazards until WBU retire.
//   A flush input kills the held instruction on a branch or trap redirect.
// PARAMETERS
//   XLEN        32  datapath width of instr, pc and imm
//   REG_AW      4   register address width (4 = RV32E, 5 = RV32I)
//   MAX_INFL    3   maximum outstanding writes per register, range 1..7
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-low
//   ifu_valid    in   1       instr/pc valid from IFU
//   idu_ready    out  1       IDU accepts instr this cycle
//   instr        in   32      fetched instruction
//   pc           in   XLEN    pc of instr
//   idu_valid    out  1       output register holds a live instruction
//   exu_ready    in   1       EXU accepts the output this cycle
//   flush        in   1       kill the output register contents (redirect)
//   wbu_valid    in   1       WBU retires a register write this cycle
//   wbu_rd       in   REG_AW  destination of the retired write
//   out_pc       out  XLEN    registered pc
//   out_rs1/rs2  out  REG_AW  registered source indices
//   out_rd       out  REG_AW  registered destination index
//   out_imm      out  XLEN    registered sign-extended immediate (I/S/B/U/J)
//   out_type     out  3       InstrType encoding (R/I/S/B/U/J)
//   out_reg_wr   out  1       instruction writes rd (forced 0 when rd==0)
//   out_illegal  out  1       opcode is not in the supported table
// BEHAVIOUR
// - Reset (rst==0, async): idu_valid=0; all out_* = 0; every scoreboard count = 0.
//   Reset applied mid-operation drops any held instruction. No transaction
//   crosses the reset edge.
// - Field extraction: rs1=instr[15+:REG_AW], rs2=instr[20+:REG_AW],
//   rd=instr[7+:REG_AW]. Upper address bits are ignored when REG_AW=4.
//   Shift-immediate I-type uses zero-extended shamt instr[24:20].
// - Source use: uses_rs1 for R/I/S/B types. uses_rs2 for R/S/B types.
//   Register x0 is never tracked and never causes a hazard.
// - Hazard: uses_rsN && cnt[rsN]!=0, or reg_wr && cnt[rd]==MAX_INFL.
//   The check uses the registered count only, with no same-cycle WBU bypass.
// - Handshake:
//     idu_ready = rst && !hazard && (!idu_valid || exu_ready) && !flush.
//     Input accept = ifu_valid && idu_ready. The output register loads on the
//     next clk edge. Latency is 1 cycle.
//     Output fire = idu_valid && exu_ready. If there is no new accept, idu_valid
//     clears. Fire and accept in the same cycle give back-to-back throughput.
//     When idu_valid=1 and exu_ready=0, all out_* hold stable.
//     idu_ready is combinationally dependent on ifu instr through hazard.
//     IFU must not make ifu_valid depend on idu_ready.
// - Scoreboard: one CNT_W = clog2(MAX_INFL+1) bit counter per register 1..2^REG_AW-1.
//     inc(r) on input accept with reg_wr and rd=r.
//     dec(r) on wbu_valid with wbu_rd=r!=0.
//     dec(r) on flush while idu_valid && out_reg_wr with out_rd=r.
//     Multiple events on one register in a cycle sum arithmetically,
//     e.g. inc+dec gives net 0, and dec+dec gives -2.
//     A decrement at count 0 is a protocol error: the counter holds 0 and a
//     simulation-only $error fires. The hazard rule prevents increment beyond
//     MAX_INFL.
// - Flush: idu_valid clears on the next edge. The output does not fire in the
//     flush cycle. No instruction is accepted in the flush cycle.
//     Instructions already past the IDU still retire through WBU normally.
// - Illegal opcode: out_illegal=1, out_reg_wr=0, uses_rs1=uses_rs2=0.
//     The instruction passes downstream for trap handling.
// TESTING
// 1. Reset: hold rst=0 with ifu_valid=1 and random instr.
//    -> idu_valid=0, idu_ready=0, all counts 0. Release rst -> idu_ready=1.
// 2. Throughput: stream addi x1..x5 (independent) with exu_ready=1 and wbu_valid
//    retiring each write.
//    -> idu_valid at cycles 1..5 with no bubbles; out_imm matches the
//       sign-extended immediate, e.g. addi x1,x0,-1 gives 0xFFFFFFFF.
// 3. RAW stall: issue addi x3,x0,7, then add x4,x3,x3.
//    -> idu_ready=0 until the cycle after wbu_valid with wbu_rd=3.
//       Second instr out 2 cycles after that retire.
// 4. Backpressure: exu_ready=0 for 4 cycles with idu_valid=1.
//    -> out_* stable, idu_ready=0. Release -> next instr accepted the same cycle.
// 5. Flush: hold lui x2 in the output register with exu_ready=0, then flush=1.
//    -> idu_valid=0 next cycle, cnt[2] returns to 0, and add x5,x2,x0 is not
//       stalled afterwards.
// 6. Saturation (MAX_INFL=3): four addi x6 issued without retire.
//    -> the 4th stalls. wbu_valid with wbu_rd=6 unblocks it the next cycle.
//    Also check inc+dec on x6 in the same cycle leaves the count unchanged.

Source files
------------

// File: rtl/idu_pipe.sv
// Decode stage: registers RV32I/E fields and immediate; pending-write counters stall RAW hazards.
// Latency 1 cycle; ready drops on hazard, on a held output without exu_ready, or on flush.
module idu_pipe #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_INFL = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ifu_valid_i,
    output logic              idu_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              idu_valid_o,
    input  logic              exu_ready_i,
    input  logic              flush_i,
    input  logic              wbu_valid_i,
    input  logic [REG_AW-1:0] wbu_rd_i,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [REG_AW-1:0] out_rs1_o,
    output logic [REG_AW-1:0] out_rs2_o,
    output logic [REG_AW-1:0] out_rd_o,
    output logic [XLEN-1:0]   out_imm_o,
    output logic [2:0]        out_type_o,
    output logic              out_reg_wr_o,
    output logic              out_illegal_o
);
    localparam int NREG  = 1 << REG_AW;
    localparam int CNT_W = $clog2(MAX_INFL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFL);

    localparam logic [2:0] TY_R = 3'd0;
    localparam logic [2:0] TY_I = 3'd1;
    localparam logic [2:0] TY_S = 3'd2;
    localparam logic [2:0] TY_B = 3'd3;
    localparam logic [2:0] TY_U = 3'd4;
    localparam logic [2:0] TY_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [2:0]        typ;
        logic              reg_wr;
        logic              illegal;
    } dec_t;

    dec_t        id, out_q, out_d;
    logic        valid_q, valid_d;
    logic        uses_rs1, uses_rs2, hazard, accept, fire;
    logic        wr_type;
    logic [31:0] imm32;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  uflow;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        imm32      = '0;
        wr_type    = 1'b0;
        id.typ     = TY_R;
        id.illegal = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: begin
                id.typ  = TY_U;
                imm32   = {instr_i[31:12], 12'b0};
                wr_type = 1'b1;
            end
            7'b1101111: begin
                id.typ  = TY_J;
                imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
                wr_type = 1'b1;
            end
            7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: begin
                id.typ  = TY_I;
                imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                wr_type = 1'b1;
            end
            7'b0010011: begin
                id.typ  = TY_I;
                // shifts carry funct7 in the upper immediate bits, so only shamt is kept
                if (funct3 == 3'b001 || funct3 == 3'b101) imm32 = {27'b0, instr_i[24:20]};
                else                                      imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                wr_type = 1'b1;
            end
            7'b0100011: begin
                id.typ = TY_S;
                imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b1100011: begin
                id.typ = TY_B;
                imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
            end
            7'b0110011: begin
                id.typ  = TY_R;
                wr_type = 1'b1;
            end
            default: id.illegal = 1'b1;
        endcase
        id.pc     = pc_i;
        id.rs1    = instr_i[15 +: REG_AW];
        id.rs2    = instr_i[20 +: REG_AW];
        id.rd     = instr_i[7 +: REG_AW];
        id.imm    = XLEN'($signed(imm32));
        id.reg_wr = wr_type && (id.rd != '0);
    end

    assign uses_rs1 = !id.illegal && (id.typ == TY_R || id.typ == TY_I ||
                                      id.typ == TY_S || id.typ == TY_B);
    assign uses_rs2 = !id.illegal && (id.typ == TY_R || id.typ == TY_S || id.typ == TY_B);

    assign hazard = (uses_rs1 && id.rs1 != '0 && cnt_q[id.rs1] != '0) ||
                    (uses_rs2 && id.rs2 != '0 && cnt_q[id.rs2] != '0) ||
                    (id.reg_wr && cnt_q[id.rd] == CNT_MAX);

    assign idu_ready_o = rst_ni && !hazard && (!valid_q || exu_ready_i) && !flush_i;
    assign accept      = ifu_valid_i && idu_ready_o;
    assign fire        = valid_q && exu_ready_i;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (accept) begin
            out_d   = id;
            valid_d = 1'b1;
        end else if (fire || flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // x0 is never tracked; its counter stays at zero
    assign cnt_d[0] = '0;
    assign uflow[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic           inc_ev, wb_ev, fl_ev;
        logic [CNT_W:0] up;
        logic [1:0]     down;
        assign inc_ev   = accept && id.reg_wr && (id.rd == REG_AW'(r));
        assign wb_ev    = wbu_valid_i && (wbu_rd_i == REG_AW'(r));
        assign fl_ev    = flush_i && valid_q && out_q.reg_wr && (out_q.rd == REG_AW'(r));
        assign up       = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc_ev);
        assign down     = {1'b0, wb_ev} + {1'b0, fl_ev};
        assign uflow[r] = up < (CNT_W+1)'(down);
        assign cnt_d[r] = uflow[r] ? '0 : CNT_W'(up - (CNT_W+1)'(down));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (uflow == '0)
                else $error("idu_pipe: pending-write decrement at zero count, regs=%h", uflow);
        end
    end

    assign idu_valid_o   = valid_q;
    assign out_pc_o      = out_q.pc;
    assign out_rs1_o     = out_q.rs1;
    assign out_rs2_o     = out_q.rs2;
    assign out_rd_o      = out_q.rd;
    assign out_imm_o     = out_q.imm;
    assign out_type_o    = out_q.typ;
    assign out_reg_wr_o  = out_q.reg_wr;
    assign out_illegal_o = out_q.illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: expected decode records queued at accept, compared at output fire.
module tb_idu_pipe;
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        wr;
        logic        ill;
    } exp_t;

    logic        clk, rst_n, ifu_valid, idu_ready, idu_valid, exu_ready, flush, wbu_valid;
    logic [31:0] instr, pc;
    logic [3:0]  wbu_rd;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_type;
    logic        out_reg_wr, out_illegal;

    idu_pipe dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ifu_valid_i(ifu_valid), .idu_ready_o(idu_ready),
        .instr_i(instr), .pc_i(pc),
        .idu_valid_o(idu_valid), .exu_ready_i(exu_ready), .flush_i(flush),
        .wbu_valid_i(wbu_valid), .wbu_rd_i(wbu_rd),
        .out_pc_o(out_pc), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
        .out_imm_o(out_imm), .out_type_o(out_type),
        .out_reg_wr_o(out_reg_wr), .out_illegal_o(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    exp_t        q[$];
    exp_t        stage, obs_seen;
    logic        rdy_seen, val_seen, acc_seen, fire_seen;
    logic [31:0] pc_ctr;
    int          total, bad;

    function automatic exp_t obs();
        return '{pc: out_pc, rs1: out_rs1, rs2: out_rs2, rd: out_rd, imm: out_imm,
                 typ: out_type, wr: out_reg_wr, ill: out_illegal};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        rdy_seen  = idu_ready;
        val_seen  = idu_valid;
        acc_seen  = ifu_valid && idu_ready;
        fire_seen = idu_valid && exu_ready && !flush;
        obs_seen  = obs();
        if (fire_seen) begin
            if (q.size() == 0) begin
                chk("out_queue_nonempty", 128'(q.size()), 128'(1));
            end else begin
                e = q.pop_front();
                chk("out_record", 128'(obs_seen), 128'(e));
            end
        end
        if (acc_seen) q.push_back(stage);
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] typ,
                           input logic wr, input logic ill);
        stage = '{pc: pc_ctr, rs1: ins[18:15], rs2: ins[23:20], rd: ins[10:7], imm: imm,
                  typ: typ, wr: wr, ill: ill};
        instr     = ins;
        pc        = pc_ctr;
        ifu_valid = 1'b1;
        pc_ctr    = pc_ctr + 32'd4;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] typ,
                         input logic wr, input logic ill, output int waited);
        present(ins, imm, typ, wr, ill);
        waited = 0;
        step();
        while (!acc_seen && waited < 20) begin
            waited++;
            step();
        end
        ifu_valid = 1'b0;
        chk("accept_in_budget", 128'(acc_seen), 128'(1));
    endtask

    task automatic retire(input logic [3:0] r);
        wbu_valid = 1'b1;
        wbu_rd    = r;
        step();
        wbu_valid = 1'b0;
    endtask

    initial begin
        int          w;
        logic [11:0] tp_imm [5];
        logic [31:0] tp_exp [5];
        exp_t        held;
        tp_imm = '{12'hFFF, 12'h7FF, 12'h800, 12'h005, 12'h000};
        tp_exp = '{32'hFFFF_FFFF, 32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0005, 32'h0000_0000};
        total = 0; bad = 0; pc_ctr = 32'h8000_0000;
        flush = 1'b0; wbu_valid = 1'b0; wbu_rd = '0; exu_ready = 1'b1;

        // reset held with live-looking input
        rst_n = 1'b0; ifu_valid = 1'b1; instr = $urandom; pc = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(idu_valid), 128'(0));
        chk("rst_ready", 128'(idu_ready), 128'(0));
        chk("rst_outs", 128'(obs()), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; ifu_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(idu_ready), 128'(1));
        @(posedge clk); #1;

        // back-to-back independent addi stream
        for (int k = 0; k < 5; k++) begin
            issue(enc_i(tp_imm[k], 5'd0, 3'b000, 5'(k + 1), 7'h13), tp_exp[k], T_I, 1'b1, 1'b0, w);
            chk("tp_wait", 128'(w), 128'(0));
            if (k > 0) chk("tp_fire", 128'(fire_seen), 128'(1));
        end
        step();
        chk("tp_last_fire", 128'(fire_seen), 128'(1));
        chk("tp_drained", 128'(q.size()), 128'(0));
        for (int r = 1; r <= 5; r++) retire(4'(r));

        // immediate formats, x0 destination, illegal opcode
        issue(enc_i(12'h403, 5'd1, 3'b101, 5'd10, 7'h13), 32'h0000_0003, T_I, 1'b1, 1'b0, w);
        issue(enc_s(12'hFFC, 5'd5, 5'd1), 32'hFFFF_FFFC, T_S, 1'b0, 1'b0, w);
        issue(enc_b(13'h1FF8, 5'd2, 5'd1), 32'hFFFF_FFF8, T_B, 1'b0, 1'b0, w);
        issue(enc_i(12'h001, 5'd0, 3'b000, 5'd0, 7'h13), 32'h0000_0001, T_I, 1'b0, 1'b0, w);
        issue(32'hFFFF_FFFF, 32'h0, T_R, 1'b0, 1'b1, w);
        issue(enc_i(12'h008, 5'd2, 3'b000, 5'd11, 7'h67), 32'h0000_0008, T_I, 1'b1, 1'b0, w);
        issue(enc_j(21'h000800, 5'd1), 32'h0000_0800, T_J, 1'b1, 1'b0, w);
        step();
        retire(4'd10); retire(4'd11); retire(4'd1);

        // RAW stall on x3 until its write retires
        issue(enc_i(12'h007, 5'd0, 3'b000, 5'd3, 7'h13), 32'h7, T_I, 1'b1, 1'b0, w);
        present(enc_r(5'd3, 5'd3, 5'd4), 32'h0, T_R, 1'b1, 1'b0);
        repeat (3) begin
            step();
            chk("raw_stall", 128'(rdy_seen), 128'(0));
        end
        wbu_valid = 1'b1; wbu_rd = 4'd3;
        step();
        chk("raw_no_bypass", 128'(rdy_seen), 128'(0));
        wbu_valid = 1'b0;
        step();
        chk("raw_accept_after_retire", 128'(acc_seen), 128'(1));
        ifu_valid = 1'b0;
        step();
        chk("raw_out_timing", 128'(fire_seen), 128'(1));
        retire(4'd4);

        // EXU backpressure holds the output register
        exu_ready = 1'b0;
        issue(enc_i(12'h005, 5'd0, 3'b000, 5'd7, 7'h13), 32'h5, T_I, 1'b1, 1'b0, w);
        held = obs();
        present(enc_i(12'h006, 5'd0, 3'b000, 5'd8, 7'h13), 32'h6, T_I, 1'b1, 1'b0);
        repeat (4) begin
            step();
            chk("bp_valid", 128'(val_seen), 128'(1));
            chk("bp_ready", 128'(rdy_seen), 128'(0));
            chk("bp_stable", 128'(obs_seen), 128'(held));
        end
        exu_ready = 1'b1;
        step();
        chk("bp_release_accept", 128'(acc_seen), 128'(1));
        ifu_valid = 1'b0;
        step();
        retire(4'd7); retire(4'd8);

        // flush kills a held lui x2 and releases its pending write
        exu_ready = 1'b0;
        issue({20'h12345, 5'd2, 7'h37}, 32'h1234_5000, T_U, 1'b1, 1'b0, w);
        chk("lui_imm", 128'(out_imm), 128'(32'h1234_5000));
        flush = 1'b1;
        present(enc_r(5'd0, 5'd2, 5'd5), 32'h0, T_R, 1'b1, 1'b0);
        step();
        chk("fl_ready", 128'(rdy_seen), 128'(0));
        chk("fl_no_accept", 128'(acc_seen), 128'(0));
        flush = 1'b0;
        void'(q.pop_back());
        step();
        chk("fl_valid_cleared", 128'(val_seen), 128'(0));
        chk("fl_no_stall", 128'(acc_seen), 128'(1));
        ifu_valid = 1'b0; exu_ready = 1'b1;
        step();
        retire(4'd5);

        // saturation of x6 at three outstanding writes
        for (int k = 1; k <= 3; k++) begin
            issue(enc_i(12'(k), 5'd0, 3'b000, 5'd6, 7'h13), 32'(k), T_I, 1'b1, 1'b0, w);
            chk("sat_fill_wait", 128'(w), 128'(0));
        end
        present(enc_i(12'h004, 5'd0, 3'b000, 5'd6, 7'h13), 32'h4, T_I, 1'b1, 1'b0);
        step();
        chk("sat_stall", 128'(rdy_seen), 128'(0));
        wbu_valid = 1'b1; wbu_rd = 4'd6;
        step();
        chk("sat_no_bypass", 128'(rdy_seen), 128'(0));
        wbu_valid = 1'b0;
        step();
        chk("sat_unblock", 128'(acc_seen), 128'(1));
        ifu_valid = 1'b0;
        step();
        retire(4'd6);
        // count 2: inc and dec together must leave it at 2
        present(enc_i(12'h005, 5'd0, 3'b000, 5'd6, 7'h13), 32'h5, T_I, 1'b1, 1'b0);
        wbu_valid = 1'b1; wbu_rd = 4'd6;
        step();
        chk("incdec_accept", 128'(acc_seen), 128'(1));
        wbu_valid = 1'b0; ifu_valid = 1'b0;
        issue(enc_i(12'h006, 5'd0, 3'b000, 5'd6, 7'h13), 32'h6, T_I, 1'b1, 1'b0, w);
        chk("incdec_third_slot", 128'(w), 128'(0));
        present(enc_i(12'h007, 5'd0, 3'b000, 5'd6, 7'h13), 32'h7, T_I, 1'b1, 1'b0);
        step();
        chk("incdec_full_again", 128'(rdy_seen), 128'(0));
        ifu_valid = 1'b0;
        step();
        retire(4'd6); retire(4'd6); retire(4'd6);
        issue(enc_r(5'd6, 5'd6, 5'd9), 32'h0, T_R, 1'b1, 1'b0, w);
        chk("x6_cleared_wait", 128'(w), 128'(0));
        step();
        retire(4'd9);
        chk("final_queue_empty", 128'(q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
